// File: rtl/tape_mem_arb.sv
// Two-requester read arbiter for the tape player and block-header parser,
// sharing one memory read port with a per-read timeout.
module tape_mem_arb #(
    parameter logic [23:0] TIMEOUT    = 24'd4_000_000,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        r0_req,
    input  logic [24:0] r0_addr,
    output logic        r0_ack,
    output logic [7:0]  r0_data,
    input  logic        r1_req,
    input  logic [24:0] r1_addr,
    output logic        r1_ack,
    output logic [7:0]  r1_data,
    output logic        mem_rd,
    output logic [24:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_din,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [23:0] TC = TIMEOUT - 24'd1;

    state_t      state, state_n;
    logic        mem_rd_n;
    logic [24:0] mem_addr_n;
    logic        gnt, gnt_n;
    logic        last, last_n;
    logic [23:0] cnt, cnt_n;
    logic        old_ack;
    logic [7:0]  r0_data_n, r1_data_n;
    logic        timeout_err_n;
    logic        win;
    logic        ack_rise;

    assign ack_rise    = mem_ack & ~old_ack;
    assign busy        = (state != IDLE);
    assign r0_ack      = (state == ACK) && !gnt;
    assign r1_ack      = (state == ACK) && gnt;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            gnt         <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            old_ack     <= 1'b0;
            r0_data     <= '0;
            r1_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            mem_rd      <= mem_rd_n;
            mem_addr    <= mem_addr_n;
            gnt         <= gnt_n;
            last        <= last_n;
            cnt         <= cnt_n;
            old_ack     <= mem_ack;
            r0_data     <= r0_data_n;
            r1_data     <= r1_data_n;
            timeout_err <= timeout_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        mem_rd_n      = mem_rd;
        mem_addr_n    = mem_addr;
        gnt_n         = gnt;
        last_n        = last;
        cnt_n         = cnt;
        r0_data_n     = r0_data;
        r1_data_n     = r1_data;
        timeout_err_n = timeout_err;
        win           = r1_req;
        // under contention the pointer decides unless r0 has fixed priority
        if (r0_req && r1_req) begin
            win = FIXED_PRIO ? 1'b0 : ~last;
        end
        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    mem_addr_n = win ? r1_addr : r0_addr;
                    mem_rd_n   = 1'b1;
                    gnt_n      = win;
                    last_n     = win;
                    cnt_n      = '0;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (ack_rise) begin
                    if (gnt) r1_data_n = mem_din;
                    else     r0_data_n = mem_din;
                    mem_rd_n = 1'b0;
                    state_n  = ACK;
                end else if (cnt == TC) begin
                    if (gnt) r1_data_n = 8'hFF;
                    else     r0_data_n = 8'hFF;
                    mem_rd_n      = 1'b0;
                    timeout_err_n = 1'b1;
                    state_n       = ACK;
                end else begin
                    cnt_n = cnt + 24'd1;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tape_mem_arb.sv
// Scoreboard bench: expected acks are queued as requests are driven and
// matched against every ack pulse the two arbiter instances produce.
module tb_tape_mem_arb;

    typedef struct packed {
        logic        id;
        logic [24:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    // instance a: round-robin, instance b: fixed priority; both TIMEOUT=16
    logic        a_r0_req, a_r1_req, a_r0_ack, a_r1_ack, a_mem_rd, a_mem_ack, a_busy, a_timeout_err;
    logic [24:0] a_r0_addr, a_r1_addr, a_mem_addr;
    logic [7:0]  a_r0_data, a_r1_data, a_mem_din;
    logic        b_r0_req, b_r1_req, b_r0_ack, b_r1_ack, b_mem_rd, b_mem_ack, b_busy, b_timeout_err;
    logic [24:0] b_r0_addr, b_r1_addr, b_mem_addr;
    logic [7:0]  b_r0_data, b_r1_data, b_mem_din;

    logic        a_auto, man_ack;
    logic [7:0]  man_din;
    logic        ra_ack, rb_ack;
    logic [7:0]  ra_din, rb_din;
    int          ra_cnt, rb_cnt;

    int errors = 0;
    int checks = 0;
    exp_t sbq_a[$];
    exp_t sbq_b[$];

    assign a_mem_ack = a_auto ? ra_ack : man_ack;
    assign a_mem_din = a_auto ? ra_din : man_din;
    assign b_mem_ack = rb_ack;
    assign b_mem_din = rb_din;

    tape_mem_arb #(.TIMEOUT(24'd16), .FIXED_PRIO(1'b0)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .r0_req(a_r0_req), .r0_addr(a_r0_addr), .r0_ack(a_r0_ack), .r0_data(a_r0_data),
        .r1_req(a_r1_req), .r1_addr(a_r1_addr), .r1_ack(a_r1_ack), .r1_data(a_r1_data),
        .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_ack(a_mem_ack), .mem_din(a_mem_din),
        .busy(a_busy), .timeout_err(a_timeout_err));

    tape_mem_arb #(.TIMEOUT(24'd16), .FIXED_PRIO(1'b1)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .r0_req(b_r0_req), .r0_addr(b_r0_addr), .r0_ack(b_r0_ack), .r0_data(b_r0_data),
        .r1_req(b_r1_req), .r1_addr(b_r1_addr), .r1_ack(b_r1_ack), .r1_data(b_r1_data),
        .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack), .mem_din(b_mem_din),
        .busy(b_busy), .timeout_err(b_timeout_err));

    function automatic logic [7:0] din_of(input logic [24:0] addr);
        return addr[7:0] ^ 8'h86;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // memory model: ack rises on the third negedge with mem_rd high, falls with mem_rd
    always @(negedge clk_sys) begin
        if (!a_mem_rd || !a_auto) begin
            ra_ack = 1'b0; ra_cnt = 0;
        end else if (!ra_ack) begin
            if (ra_cnt == 2) begin ra_ack = 1'b1; ra_din = din_of(a_mem_addr); end
            else ra_cnt++;
        end
        if (!b_mem_rd) begin
            rb_ack = 1'b0; rb_cnt = 0;
        end else if (!rb_ack) begin
            if (rb_cnt == 2) begin rb_ack = 1'b1; rb_din = din_of(b_mem_addr); end
            else rb_cnt++;
        end
    end

    task automatic score(input int k, input logic a0, input logic a1,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [24:0] ma);
        exp_t e;
        if (!(a0 || a1)) return;
        if ((k == 0 && sbq_a.size() == 0) || (k == 1 && sbq_b.size() == 0)) begin
            check($sformatf("unexpected_ack_%0d", k), {30'd0, a1, a0}, 32'd0);
            return;
        end
        e = (k == 0) ? sbq_a.pop_front() : sbq_b.pop_front();
        check($sformatf("dual_ack_%0d", k), {31'd0, a0 & a1}, 32'd0);
        check($sformatf("ack_id_%0d", k), {31'd0, a1}, {31'd0, e.id});
        check($sformatf("ack_data_%0d", k), {24'd0, a1 ? d1 : d0}, {24'd0, e.data});
        check($sformatf("ack_addr_%0d", k), {7'd0, ma}, {7'd0, e.addr});
    endtask

    always @(negedge clk_sys) begin
        score(0, a_r0_ack, a_r1_ack, a_r0_data, a_r1_data, a_mem_addr);
        score(1, b_r0_ack, b_r1_ack, b_r0_data, b_r1_data, b_mem_addr);
    end

    task automatic wait_ack_a(input string tag, output int ncyc, output int nrd);
        logic seen;
        seen = 1'b0; ncyc = 0; nrd = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_sys);
            ncyc++;
            if (a_mem_rd) nrd++;
            if (a_r0_ack || a_r1_ack) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int ncyc, nrd, na, nb;
        reset_n = 1'b0;
        a_r0_req = 0; a_r1_req = 0; a_r0_addr = '0; a_r1_addr = '0;
        b_r0_req = 0; b_r1_req = 0; b_r0_addr = '0; b_r1_addr = '0;
        a_auto = 1'b1; man_ack = 1'b0; man_din = '0;
        ra_ack = 0; rb_ack = 0; ra_din = '0; rb_din = '0; ra_cnt = 0; rb_cnt = 0;
        repeat (2) @(negedge clk_sys);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_mem_rd", {31'd0, a_mem_rd}, 32'd0);
        check("rst_mem_addr", {7'd0, a_mem_addr}, 32'd0);
        check("rst_data", {16'd0, a_r0_data, a_r1_data}, 32'd0);
        check("rst_tmo", {31'd0, a_timeout_err}, 32'd0);
        reset_n = 1'b1;

        // single read from the tape player
        @(negedge clk_sys);
        sbq_a.push_back('{1'b0, 25'h000123, 8'hA5});
        a_r0_addr = 25'h000123; a_r0_req = 1'b1;
        wait_ack_a("single_ack", ncyc, nrd);
        a_r0_req = 1'b0;
        check("single_latency", ncyc, 4);
        check("single_r0_data", {24'd0, a_r0_data}, 32'hA5);
        check("busy_in_ack", {31'd0, a_busy}, 32'd1);
        @(negedge clk_sys);
        check("busy_idle", {31'd0, a_busy}, 32'd0);

        // contention: round-robin on a, fixed priority on b, from reset
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        a_r0_addr = 25'h0000040; a_r1_addr = 25'h1F0000F;
        b_r0_addr = 25'h0000040; b_r1_addr = 25'h1F0000F;
        for (int i = 0; i < 4; i++) begin
            sbq_a.push_back('{i[0], i[0] ? a_r1_addr : a_r0_addr, din_of(i[0] ? a_r1_addr : a_r0_addr)});
            sbq_b.push_back('{1'b0, b_r0_addr, din_of(b_r0_addr)});
        end
        a_r0_req = 1; a_r1_req = 1; b_r0_req = 1; b_r1_req = 1;
        na = 0; nb = 0;
        for (int i = 0; i < 200 && (na < 4 || nb < 4); i++) begin
            @(negedge clk_sys);
            if (a_r0_ack || a_r1_ack) begin
                na++;
                if (na == 4) begin a_r0_req = 0; a_r1_req = 0; end
            end
            if (b_r0_ack || b_r1_ack) begin
                nb++;
                if (nb == 4) begin b_r0_req = 0; b_r1_req = 0; end
            end
        end
        check("rr_ack_count", na, 4);
        check("fp_ack_count", nb, 4);
        check("fp_r1_never", {24'd0, b_r1_data}, 32'd0);
        a_auto = 1'b0;
        @(negedge clk_sys);

        // timeout on r1 with mem_ack held low; address change mid-read ignored
        sbq_a.push_back('{1'b1, 25'h0ABCD12, 8'hFF});
        a_r1_addr = 25'h0ABCD12; a_r1_req = 1'b1;
        repeat (3) @(negedge clk_sys);
        a_r1_addr = 25'h1111111;
        @(negedge clk_sys);
        check("addr_hold", {7'd0, a_mem_addr}, {7'd0, 25'h0ABCD12});
        wait_ack_a("tmo_ack", ncyc, nrd);
        a_r1_req = 1'b0;
        check("tmo_rd_cycles", nrd + 4, 16);   // four mem_rd-high negedges elapsed before the wait
        check("tmo_err_set", {31'd0, a_timeout_err}, 32'd1);
        check("tmo_r1_data", {24'd0, a_r1_data}, 32'hFF);
        @(negedge clk_sys);

        // mem_ack already high at grant must not complete the read
        sbq_a.push_back('{1'b0, 25'h1ABCDE0, 8'h5E});
        man_ack = 1'b1; man_din = 8'h11;
        a_r0_addr = 25'h1ABCDE0; a_r0_req = 1'b1;
        repeat (6) @(negedge clk_sys);
        check("held_ack_rd", {31'd0, a_mem_rd}, 32'd1);
        man_ack = 1'b0;
        @(negedge clk_sys);
        man_ack = 1'b1; man_din = 8'h5E;
        wait_ack_a("held_ack_done", ncyc, nrd);
        a_r0_req = 1'b0; man_ack = 1'b0;
        check("tmo_err_sticky", {31'd0, a_timeout_err}, 32'd1);
        @(negedge clk_sys);

        // reset in WAIT, then a stale mem_ack edge in IDLE
        a_r1_addr = 25'h0000777; a_r1_req = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("pre_rst_busy", {30'd0, a_busy, a_mem_rd}, 32'd3);
        reset_n = 1'b0; a_r1_req = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        check("wait_rst_rd", {31'd0, a_mem_rd}, 32'd0);
        check("wait_rst_busy", {31'd0, a_busy}, 32'd0);
        check("wait_rst_tmo", {31'd0, a_timeout_err}, 32'd0);
        check("wait_rst_r1_data", {24'd0, a_r1_data}, 32'd0);
        @(negedge clk_sys);
        man_ack = 1'b1; man_din = 8'h42;
        repeat (3) @(negedge clk_sys);
        check("stale_ack_idle", {30'd0, a_busy, a_mem_rd}, 32'd0);
        man_ack = 1'b0;
        @(negedge clk_sys);

        check("sbq_a_empty", sbq_a.size(), 0);
        check("sbq_b_empty", sbq_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
